// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared register-file constants and the register index type
//               used across the integer pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter
// Description : Outstanding-write counter for one architectural register.
//               One increment and two independent decrements per cycle.
//               The result clamps at 0 (protocol error, asserted) and at the
//               counter maximum.
// Ports       : i_clk, i_rst_n   clock, async active-low reset
//               i_inc            write issued to this register
//               i_dec_a, i_dec_b writeback / downstream-kill retire
//               o_cnt            current count
//               o_sat            count at maximum
//               o_nz             count non-zero
// Revision    : 1.0 - initial release
// ============================================================================
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_dec_a,
    input  logic             i_dec_b,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat,
    output logic             o_nz
);

    localparam logic [CNT_W:0] c_max = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_up;
    logic [CNT_W:0]   w_down;
    logic [CNT_W:0]   w_next;
    logic             w_underflow;

    // One guard bit so the sum and the difference never wrap.
    assign w_up        = {1'b0, r_cnt} + (CNT_W+1)'(i_inc);
    assign w_down      = (CNT_W+1)'(i_dec_a) + (CNT_W+1)'(i_dec_b);
    assign w_underflow = (w_up < w_down);

    always_comb begin
        w_next = '0;
        if (!w_underflow) begin
            w_next = w_up - w_down;
        end
        if (w_next > c_max) begin
            w_next = c_max;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next[CNT_W-1:0];
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = (r_cnt == c_max[CNT_W-1:0]);
    assign o_nz  = (r_cnt != '0);

    a_no_underflow : assert property (@(posedge i_clk) disable iff (!i_rst_n) !w_underflow)
        else $error("sb_counter: retire of a register with no write in flight");

endmodule : sb_counter
`default_nettype wire

// File: rtl/id_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : id_scoreboard
// Description : Register-hazard scoreboard for the non-forwarding pipeline.
//               Counts in-flight writes per register from issue until
//               writeback or squash and stalls ID on any read-after-write
//               hazard or when a destination counter is saturated.
// Ports       : i_clk, i_rst_n          clock, async active-low reset
//               i_id_*                  decoded ID-stage instruction
//               i_id_flush              ID instruction squashed this cycle
//               i_wb_vld / i_wb_rd      writeback commit
//               i_kill_vld / i_kill_rd  issued write squashed downstream
//               o_stall                 hold PC and IF/ID, bubble into EX
//               o_pending               per-register write-in-flight flags
// Revision    : 1.0 - initial release
// ============================================================================
module id_scoreboard
    import rv_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_id_vld,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_is_rs1,
    input  logic                  i_id_is_rs2,
    input  logic                  i_id_rd_wren,
    input  logic                  i_id_flush,
    input  logic                  i_wb_vld,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic                  i_kill_vld,
    input  logic [REG_ADDR_W-1:0] i_kill_rd,
    output logic                  o_stall,
    output logic [NUM_REGS-1:0]   o_pending
);

    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_sat;
    logic [NUM_REGS-1:0] w_nz;
    logic                w_issue;
    logic                w_rs1_haz;
    logic                w_rs2_haz;
    logic                w_sat_haz;
    logic                w_rd_retiring;
    reg_idx_t            w_rs1;
    reg_idx_t            w_rs2;
    reg_idx_t            w_rd;

    assign w_rs1 = i_id_rs1;
    assign w_rs2 = i_id_rs2;
    assign w_rd  = i_id_rd;

    // x0 is never tracked.
    assign w_cnt[0] = '0;
    assign w_sat[0] = 1'b0;
    assign w_nz[0]  = 1'b0;

    assign w_issue = i_id_vld & ~o_stall & ~i_id_flush & i_id_rd_wren & (w_rd != '0);

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
            sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_inc   (w_issue & (w_rd == REG_ADDR_W'(r))),
                .i_dec_a (i_wb_vld & (i_wb_rd == REG_ADDR_W'(r))),
                .i_dec_b (i_kill_vld & (i_kill_rd == REG_ADDR_W'(r))),
                .o_cnt   (w_cnt[r]),
                .o_sat   (w_sat[r]),
                .o_nz    (w_nz[r])
            );
        end
    endgenerate

    // With a write-first register file, the last outstanding write landing
    // this cycle is visible to the reader, so it need not wait.
    assign w_rs1_haz = i_id_is_rs1 & w_nz[w_rs1]
                     & ~((WB_BYPASS != 0) & (w_cnt[w_rs1] == CNT_W'(1))
                         & i_wb_vld & (i_wb_rd == w_rs1));
    assign w_rs2_haz = i_id_is_rs2 & w_nz[w_rs2]
                     & ~((WB_BYPASS != 0) & (w_cnt[w_rs2] == CNT_W'(1))
                         & i_wb_vld & (i_wb_rd == w_rs2));

    // A retire of the destination in the same cycle frees a slot, so the
    // increment and decrement cancel instead of overflowing.
    assign w_rd_retiring = (i_wb_vld & (i_wb_rd == w_rd)) | (i_kill_vld & (i_kill_rd == w_rd));
    assign w_sat_haz     = i_id_rd_wren & w_sat[w_rd] & ~w_rd_retiring;

    assign o_stall   = i_id_vld & ~i_id_flush & (w_rs1_haz | w_rs2_haz | w_sat_haz);
    assign o_pending = w_nz;

endmodule : id_scoreboard
`default_nettype wire
